prio_enc_seg_scan: RTL and testbench
====================================

# prio_enc_seg_scan

Parametrised priority-encode-and-display block: CH active-low request lines are synchronised, priority-encoded (highest index wins), debounced, and shown as a two-digit decimal index on a scanned 7-segment display. It generalises the cascaded 8-line priority encoder, comparator and BCD-to-7-segment chain to any channel count up to 100. It adds enable/lamp-test/hold modes and registered, glitch-free outputs. It sits between the board input switches and the display pins.

## Interface
- CH, 16, number of request lines; legal range 2..100
- DEB, 4, consecutive cycles a new code must be stable before it is accepted; ≥1
- SCAN_DIV, 1000, clock cycles per digit during display scan; ≥2
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- data_in  in  CH  request lines, active-low; bit i low requests code i
- ei_n  in  1  enable, active-low; high forces "no request"
- hold  in  1  high freezes the accepted code
- lt_n  in  1  lamp test, active-low; all seven segments lit on the selected digit
- seg  out  8  segments, active-high; seg[0]=a … seg[6]=g, seg[7]=dp, always 0
- dig  out  2  digit enables, active-low; dig[0]=ones, dig[1]=tens
- gs  out  1  group select, active-low; 0 when accepted state is "request present"
- eo  out  1  enable out, active-low; 0 when enabled and accepted state is "no request"
- code  out  $clog2(CH)  accepted index; 0 when no request
- upd  out  1  one-cycle pulse when the accepted code or gs changes

## Operation
- Input path: a two-flop synchroniser per bit (s1, s2) feeds a combinational priority encoder.
  - Encoder output is a candidate {present, idx}: idx = highest i with s2[i]==0.
  - present=0 if no bit is low or ei_n==1 (ei_n also passes through the two-flop synchroniser).
- Candidate register cand captures the encoder output every cycle.
- Debounce counter cnt, width $clog2(DEB+1):
  - cleared to 0 on any edge where cand loads a different value;
  - otherwise increments, saturating at DEB-1.
- Acceptance: on an edge where cnt==DEB-1, hold==0, and cand differs from the accepted value, the accepted {present, code} loads cand and upd=1.
  - While hold==1, acceptance is blocked; cnt keeps running.
  - On hold release, acceptance occurs on the first edge with hold==0 if cnt==DEB-1.
- gs = ~present; eo = present | ei_sync (registered with the accepted value).
- BCD: tens = code/10, ones = code%10 (combinational; CH≤100 bounds tens to 0..9).
- Scan: divider sdiv counts 0..SCAN_DIV-1; on wrap, sel toggles (0=ones, 1=tens).
- Segment register, per cycle:
  - if lt_n==0: 0x7F;
  - else if present==0: 0x00;
  - else if sel==1 and tens==0: 0x00 (leading-zero blank);
  - else: the pattern for the selected digit.
- dig register = ~(1<<sel).
- Patterns 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.

## Timing
- Reset values:
  - s1/s2/cand = "no request"; cnt=0; sdiv=0; sel=0.
  - seg=0x00, dig=2'b11, gs=1, eo=1, code=0, upd=0.
  - First digit is driven on the edge after rst deasserts.
- Latency: a pin change sampled at edge E gives cand at E+2, and code/gs/eo/upd at E+2+DEB if stable throughout.
  - seg reflects the new value at E+3+DEB on the currently selected digit.
- Pulses shorter than DEB candidate cycles never reach code; no upd.
- Candidate returning to the accepted value before acceptance: no upd.
- Simultaneous hold rise and acceptance condition: hold wins.
- rst mid-debounce or mid-scan: all state returns to reset values on that edge.
- lt_n acts on the next edge with no debounce; it does not affect code/gs/eo/upd.

## Structure
- Package prio_seg_pkg holds:
  - SEG_BLANK = 8'h00 and SEG_LAMP = 8'h7F;
  - DIG_OFF = 2'b11;
  - function seg_of(bcd) returning the 8-bit pattern (dp=0).
- Sub-module seg7_dec: combinational BCD → segments with blank and lamp-test inputs. It is instantiated once, after the digit mux.

## Test plan
- Reset: assert rst 3 cycles with data_in all 1 → seg=00, dig=11, gs=1, eo=1, code=0, upd=0.
- DEB=4: data_in[5] low → code=5 and one upd exactly 6 cycles after the sampling edge; ones digit seg=6D; tens digit seg=00; gs=0, eo=1.
- data_in[3] and data_in[12] low → code=12; tens seg=06, ones seg=5B.
- Glitch: data_in[9] low for 3 cycles (< DEB), from no-request → no upd, code stays 0, seg 00.
- hold=1 then data_in[7] low → code unchanged; drop hold → code=7 with one upd on the next edge.
- ei_n=1 with data_in[2] low → after debounce gs=1, eo=1, seg=00. Then lt_n=0 → seg=7F on both digits next edge.

Source files
------------

// File: rtl/prio_enc_seg_scan_pkg.sv
// Shared constants and digit-pattern helper for the priority-encode-and-display block.
package prio_seg_pkg;

   localparam int unsigned BCD_W  = 4;
   localparam int unsigned SEG_W  = 8;
   localparam int unsigned DIG_W  = 2;
   localparam int unsigned MAX_CH = 100;

   localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
   localparam logic [SEG_W-1:0] SEG_LAMP  = 8'h7F;
   localparam logic [DIG_W-1:0] DIG_OFF   = 2'b11;

   // Segment pattern for one decimal digit, dp always off; out-of-range digits blank.
   function automatic logic [SEG_W-1:0] seg_of(input logic [BCD_W-1:0] bcd);
      logic [SEG_W-1:0] pat;
      case (bcd)
         4'd0:    pat = 8'h3F;
         4'd1:    pat = 8'h06;
         4'd2:    pat = 8'h5B;
         4'd3:    pat = 8'h4F;
         4'd4:    pat = 8'h66;
         4'd5:    pat = 8'h6D;
         4'd6:    pat = 8'h7D;
         4'd7:    pat = 8'h07;
         4'd8:    pat = 8'h7F;
         4'd9:    pat = 8'h6F;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/prio_enc_seg_scan_if.sv
// Request/mode inputs and display/status outputs of the priority-encode-and-display block.
interface prio_enc_seg_scan_if #(
   parameter int unsigned CH = 16
);
   localparam int unsigned CW = $clog2(CH);

   logic [CH-1:0] data_in;
   logic          ei_n;
   logic          hold;
   logic          lt_n;
   logic [7:0]    seg;
   logic [1:0]    dig;
   logic          gs;
   logic          eo;
   logic [CW-1:0] code;
   logic          upd;

   modport master (
      output data_in, ei_n, hold, lt_n,
      input  seg, dig, gs, eo, code, upd
   );

   modport slave (
      input  data_in, ei_n, hold, lt_n,
      output seg, dig, gs, eo, code, upd
   );
endinterface

// File: rtl/prio_enc_seg_scan_seg7_dec.sv
// Combinational BCD to 7-segment decoder with blanking and lamp test (lamp wins).
module seg7_dec
   import prio_seg_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   input  logic             blank,
   input  logic             lamp,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = seg_of(bcd);
      if (blank) seg_c = SEG_BLANK;
      if (lamp)  seg_c = SEG_LAMP;
   end

endmodule

// File: rtl/prio_enc_seg_scan.sv
// Synchronised, debounced priority encoder (highest index wins) shown as a
// two-digit decimal on a scanned 7-segment display.
module prio_enc_seg_scan
   import prio_seg_pkg::*;
#(
   parameter int unsigned CH       = 16,
   parameter int unsigned DEB      = 4,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst,
   prio_enc_seg_scan_if.slave  bus
);

   localparam int unsigned CW     = $clog2(CH);
   localparam int unsigned CNT_W  = $clog2(DEB + 1);
   localparam int unsigned SDIV_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEB - 1);
   localparam logic [SDIV_W-1:0] SDIV_MAX = SDIV_W'(SCAN_DIV - 1);

   logic [CH-1:0]     s1, s2;
   logic              ei_s1, ei_s2;
   logic              cand_present, acc_present;
   logic [CW-1:0]     cand_idx, acc_code;
   logic [CNT_W-1:0]  cnt;
   logic [SDIV_W-1:0] sdiv;
   logic              sel;
   logic [SEG_W-1:0]  seg_q;
   logic [DIG_W-1:0]  dig_q;
   logic              gs_q, eo_q, upd_q;

   logic              enc_present_c;
   logic [CW-1:0]     enc_idx_c;
   logic              accept_c;
   logic              acc_present_nx_c;
   logic [6:0]        code_ext_c;
   logic [BCD_W-1:0]  tens_c, ones_c, digit_c;
   logic              blank_c;
   logic [SEG_W-1:0]  seg_c;

   // Priority encoder: later (higher) low bits overwrite earlier ones.
   always_comb begin
      enc_present_c = 1'b0;
      enc_idx_c     = '0;
      if (!ei_s2) begin
         for (int i = 0; i < CH; i++) begin
            if (!s2[i]) begin
               enc_present_c = 1'b1;
               enc_idx_c     = CW'(i);
            end
         end
      end
   end

   always_comb begin
      accept_c = (cnt == CNT_MAX) && !bus.hold &&
                 ({cand_present, cand_idx} != {acc_present, acc_code});
      acc_present_nx_c = accept_c ? cand_present : acc_present;
   end

   // Decimal split and digit mux in front of the single decoder.
   always_comb begin
      code_ext_c = 7'(acc_code);
      tens_c     = 4'(code_ext_c / 7'd10);
      ones_c     = 4'(code_ext_c % 7'd10);
      digit_c    = sel ? tens_c : ones_c;
      blank_c    = !acc_present || (sel && (tens_c == 4'd0));
   end

   seg7_dec u_dec (
      .bcd   (digit_c),
      .blank (blank_c),
      .lamp  (!bus.lt_n),
      .seg_c (seg_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1           <= '1;
         s2           <= '1;
         ei_s1        <= 1'b1;
         ei_s2        <= 1'b1;
         cand_present <= 1'b0;
         cand_idx     <= '0;
         cnt          <= '0;
         acc_present  <= 1'b0;
         acc_code     <= '0;
         gs_q         <= 1'b1;
         eo_q         <= 1'b1;
         upd_q        <= 1'b0;
         sdiv         <= '0;
         sel          <= 1'b0;
         seg_q        <= SEG_BLANK;
         dig_q        <= DIG_OFF;
      end else begin
         s1    <= bus.data_in;
         s2    <= s1;
         ei_s1 <= bus.ei_n;
         ei_s2 <= ei_s1;

         cand_present <= enc_present_c;
         cand_idx     <= enc_idx_c;
         // Debounce restarts whenever the candidate changes, else saturates.
         if ({enc_present_c, enc_idx_c} != {cand_present, cand_idx}) cnt <= '0;
         else if (cnt != CNT_MAX)                                    cnt <= cnt + CNT_W'(1);

         if (accept_c) begin
            acc_present <= cand_present;
            acc_code    <= cand_idx;
         end
         upd_q <= accept_c;
         gs_q  <= !acc_present_nx_c;
         eo_q  <= acc_present_nx_c | ei_s2;

         if (sdiv == SDIV_MAX) begin
            sdiv <= '0;
            sel  <= !sel;
         end else begin
            sdiv <= sdiv + SDIV_W'(1);
         end
         seg_q <= seg_c;
         dig_q <= sel ? 2'b01 : 2'b10;
      end
   end

   assign bus.seg  = seg_q;
   assign bus.dig  = dig_q;
   assign bus.gs   = gs_q;
   assign bus.eo   = eo_q;
   assign bus.code = acc_code;
   assign bus.upd  = upd_q;

endmodule

// File: tb/tb_prio_enc_seg_scan.sv
// Directed bench for prio_enc_seg_scan: CH=16, DEB=4, short scan period.
module tb_prio_enc_seg_scan;

   localparam int unsigned CH = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   prio_enc_seg_scan_if #(.CH(CH)) bus ();

   prio_enc_seg_scan #(.CH(CH), .DEB(4), .SCAN_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance at least one edge, then until the wanted digit is selected (bounded).
   task automatic wait_dig(input logic [1:0] d, output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (bus.dig === d) got = 1'b1;
      end
   endtask

   task automatic wait_upd(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (bus.upd === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.data_in = '1; bus.ei_n = 1'b0; bus.hold = 1'b0; bus.lt_n = 1'b1;
      repeat (3) step();
      n_vec++; if (bus.seg !== 8'h00) begin n_err++; $display("FAIL reset_seg: got %h exp 00", bus.seg); end
      n_vec++; if (bus.dig !== 2'b11) begin n_err++; $display("FAIL reset_dig: got %b exp 11", bus.dig); end
      n_vec++; if (bus.gs !== 1'b1) begin n_err++; $display("FAIL reset_gs: got %b exp 1", bus.gs); end
      n_vec++; if (bus.eo !== 1'b1) begin n_err++; $display("FAIL reset_eo: got %b exp 1", bus.eo); end
      n_vec++; if (bus.code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d exp 0", bus.code); end
      n_vec++; if (bus.upd !== 1'b0) begin n_err++; $display("FAIL reset_upd: got %b exp 0", bus.upd); end
      rst = 1'b0;
      repeat (8) step();
      n_vec++; if (bus.eo !== 1'b0) begin n_err++; $display("FAIL idle_eo: got %b exp 0", bus.eo); end
      n_vec++; if (bus.gs !== 1'b1) begin n_err++; $display("FAIL idle_gs: got %b exp 1", bus.gs); end
      n_vec++; if (bus.seg !== 8'h00) begin n_err++; $display("FAIL idle_seg: got %h exp 00", bus.seg); end
   endtask

   task automatic test_single();
      bit got;
      logic [3:0] exp_code;
      bus.data_in = ~(16'h1 << 5);
      for (int i = 0; i < 10; i++) begin
         step();
         exp_code = (i >= 6) ? 4'd5 : 4'd0;
         n_vec++; if (bus.upd !== (i == 6)) begin n_err++; $display("FAIL single_upd[%0d]: got %b exp %b", i, bus.upd, (i == 6)); end
         n_vec++; if (bus.code !== exp_code) begin n_err++; $display("FAIL single_code[%0d]: got %0d exp %0d", i, bus.code, exp_code); end
      end
      n_vec++; if (bus.gs !== 1'b0) begin n_err++; $display("FAIL single_gs: got %b exp 0", bus.gs); end
      n_vec++; if (bus.eo !== 1'b1) begin n_err++; $display("FAIL single_eo: got %b exp 1", bus.eo); end
      wait_dig(2'b10, got);
      n_vec++; if (!got || bus.seg !== 8'h6D) begin n_err++; $display("FAIL single_ones: got %h exp 6D", bus.seg); end
      wait_dig(2'b01, got);
      n_vec++; if (!got || bus.seg !== 8'h00) begin n_err++; $display("FAIL single_tens: got %h exp 00", bus.seg); end
   endtask

   task automatic test_two_digit();
      bit got;
      bus.data_in = ~((16'h1 << 3) | (16'h1 << 12));
      wait_upd(got);
      n_vec++; if (!got || bus.code !== 4'd12) begin n_err++; $display("FAIL two_code: got %0d exp 12", bus.code); end
      wait_dig(2'b01, got);
      n_vec++; if (!got || bus.seg !== 8'h06) begin n_err++; $display("FAIL two_tens: got %h exp 06", bus.seg); end
      wait_dig(2'b10, got);
      n_vec++; if (!got || bus.seg !== 8'h5B) begin n_err++; $display("FAIL two_ones: got %h exp 5B", bus.seg); end
   endtask

   task automatic test_glitch();
      bit got;
      int upd_cnt;
      bus.data_in = '1;
      wait_upd(got);
      n_vec++; if (!got || bus.code !== 4'd0) begin n_err++; $display("FAIL release_code: got %0d exp 0", bus.code); end
      repeat (6) step();
      bus.data_in = ~(16'h1 << 9);
      repeat (3) step();
      bus.data_in = '1;
      upd_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (bus.upd === 1'b1) upd_cnt++;
      end
      n_vec++; if (upd_cnt !== 0) begin n_err++; $display("FAIL glitch_upd: got %0d pulses exp 0", upd_cnt); end
      n_vec++; if (bus.code !== 4'd0) begin n_err++; $display("FAIL glitch_code: got %0d exp 0", bus.code); end
      n_vec++; if (bus.seg !== 8'h00) begin n_err++; $display("FAIL glitch_seg: got %h exp 00", bus.seg); end
   endtask

   task automatic test_hold();
      int upd_cnt;
      bus.hold = 1'b1;
      bus.data_in = ~(16'h1 << 7);
      upd_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.upd === 1'b1) upd_cnt++;
      end
      n_vec++; if (upd_cnt !== 0) begin n_err++; $display("FAIL hold_upd: got %0d pulses exp 0", upd_cnt); end
      n_vec++; if (bus.code !== 4'd0) begin n_err++; $display("FAIL hold_code: got %0d exp 0", bus.code); end
      bus.hold = 1'b0;
      step();
      n_vec++; if (bus.upd !== 1'b1) begin n_err++; $display("FAIL release_upd: got %b exp 1", bus.upd); end
      n_vec++; if (bus.code !== 4'd7) begin n_err++; $display("FAIL release_code7: got %0d exp 7", bus.code); end
      step();
      n_vec++; if (bus.upd !== 1'b0) begin n_err++; $display("FAIL release_upd_once: got %b exp 0", bus.upd); end
   endtask

   task automatic test_enable_lamp();
      bit got;
      logic [1:0] other;
      bus.ei_n = 1'b1;
      bus.data_in = ~(16'h1 << 2);
      wait_upd(got);
      n_vec++; if (!got || bus.code !== 4'd0) begin n_err++; $display("FAIL dis_code: got %0d exp 0", bus.code); end
      n_vec++; if (bus.gs !== 1'b1) begin n_err++; $display("FAIL dis_gs: got %b exp 1", bus.gs); end
      n_vec++; if (bus.eo !== 1'b1) begin n_err++; $display("FAIL dis_eo: got %b exp 1", bus.eo); end
      wait_dig(2'b10, got);
      n_vec++; if (!got || bus.seg !== 8'h00) begin n_err++; $display("FAIL dis_ones: got %h exp 00", bus.seg); end
      wait_dig(2'b01, got);
      n_vec++; if (!got || bus.seg !== 8'h00) begin n_err++; $display("FAIL dis_tens: got %h exp 00", bus.seg); end
      bus.lt_n = 1'b0;
      step();
      n_vec++; if (bus.seg !== 8'h7F) begin n_err++; $display("FAIL lamp_first: got %h exp 7F", bus.seg); end
      other = ~bus.dig;
      wait_dig(other, got);
      n_vec++; if (!got || bus.seg !== 8'h7F) begin n_err++; $display("FAIL lamp_other: got %h exp 7F", bus.seg); end
      n_vec++; if (bus.code !== 4'd0 || bus.upd !== 1'b0) begin n_err++; $display("FAIL lamp_code: got %0d/%b exp 0/0", bus.code, bus.upd); end
      bus.lt_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_digit();
      test_glitch();
      test_hold();
      test_enable_lamp();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
